// File: rtl/pallette_sequencer_pkg.sv
// Shared definitions for the palette sequencer: palette width, state encoding
// and the default auto-cycle period.
package pallette_sequencer_pkg;

  localparam int PAL_W                   = 2;
  localparam int NUM_PAL                 = 4;
  localparam int DEFAULT_FRAMES_PER_STEP = 60;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STAGED = 1'b1
  } seq_state_t;

  // Next palette index, wrapping 3 -> 0 through natural PAL_W overflow
  function automatic logic [PAL_W-1:0] next_pal(input logic [PAL_W-1:0] cur);
    next_pal = cur + PAL_W'(1);
  endfunction

endpackage

// File: rtl/pallette_frame_timer.sv
// Counts vblank pulses while enabled and flags the pulse on which the count
// reaches FRAMES_PER_STEP-1; the count then restarts from zero.
module pallette_frame_timer #(
  parameter int FRAMES_PER_STEP = 60,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vblank_start,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic [CNT_W-1:0] count_reg;

  // Tick only on an enabled vblank that completes the period
  assign tick = enable & vblank_start & (count_reg == LAST);

  // Frame counter: clear wins, otherwise advance on enabled vblank pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && vblank_start) begin
      if (count_reg == LAST) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pallette_sequencer.sv
// Palette select owner: stages host/button/auto changes and applies them
// only on the vertical-blanking start pulse so swaps never tear mid-frame.
module pallette_sequencer
  import pallette_sequencer_pkg::*;
#(
  parameter int FRAMES_PER_STEP = DEFAULT_FRAMES_PER_STEP,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vblank_start,
  input  logic             req_valid,
  input  logic [PAL_W-1:0] req_sel,
  output logic             req_ready,
  input  logic             step_btn,
  input  logic             auto_en,
  output logic [PAL_W-1:0] select,
  output logic             pending,
  output logic             applied
);

  seq_state_t       state_reg;
  logic [PAL_W-1:0] staged_reg;
  logic [PAL_W-1:0] select_reg;
  logic             applied_reg;
  logic             step_q_reg;

  logic step_rise;
  logic timer_enable;
  logic timer_clear;
  logic auto_tick;

  assign step_rise = step_btn & ~step_q_reg;

  // The counter only runs in IDLE with auto mode on; a staged apply restarts it
  assign timer_enable = auto_en & (state_reg == ST_IDLE);
  assign timer_clear  = ~auto_en | ((state_reg == ST_STAGED) & vblank_start);

  pallette_frame_timer #(
    .FRAMES_PER_STEP (FRAMES_PER_STEP),
    .CNT_W           (CNT_W)
  ) u_frame_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .vblank_start (vblank_start),
    .enable       (timer_enable),
    .clear        (timer_clear),
    .tick         (auto_tick)
  );

  assign select    = select_reg;
  assign pending   = (state_reg == ST_STAGED);
  assign req_ready = (state_reg == ST_IDLE);
  assign applied   = applied_reg;

  // Button edge detector register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      step_q_reg <= 1'b0;
    end else begin
      step_q_reg <= step_btn;
    end
  end

  // Staging FSM with registered select and applied pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      staged_reg  <= '0;
      select_reg  <= '0;
      applied_reg <= 1'b0;
    end else begin
      applied_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // An auto advance always moves to a different index
          if (auto_tick) begin
            select_reg  <= next_pal(select_reg);
            applied_reg <= 1'b1;
          end
          // Host request beats a simultaneous button press
          if (req_valid) begin
            staged_reg <= req_sel;
            state_reg  <= ST_STAGED;
          end else if (step_rise) begin
            staged_reg <= next_pal(select_reg);
            state_reg  <= ST_STAGED;
          end
        end
        ST_STAGED: begin
          // Apply wins over a coinciding press; presses otherwise accumulate
          if (vblank_start) begin
            select_reg  <= staged_reg;
            applied_reg <= (staged_reg != select_reg);
            state_reg   <= ST_IDLE;
          end else if (step_rise) begin
            staged_reg <= next_pal(staged_reg);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pallette_sequencer.sv
// Self-checking bench for pallette_sequencer: directed checks plus a scoreboard
// of expected select values popped on every applied pulse.
module tb_pallette_sequencer;

  logic       clk;
  logic       reset_n;
  logic       vblank_start;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic       step_btn;
  logic       auto_en;
  logic [1:0] select;
  logic       pending;
  logic       applied;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_q[$];
  int exp_sel;

  pallette_sequencer #(
    .FRAMES_PER_STEP (4),
    .CNT_W           (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vblank_start (vblank_start),
    .req_valid    (req_valid),
    .req_sel      (req_sel),
    .req_ready    (req_ready),
    .step_btn     (step_btn),
    .auto_en      (auto_en),
    .select       (select),
    .pending      (pending),
    .applied      (applied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_vblank();
    vblank_start = 1'b1;
    cyc();
    vblank_start = 1'b0;
  endtask

  task automatic press_step();
    step_btn = 1'b1;
    cyc();
    step_btn = 1'b0;
    cyc();
  endtask

  task automatic host_req(input logic [1:0] sel);
    req_valid = 1'b1;
    req_sel   = sel;
    cyc();
    req_valid = 1'b0;
  endtask

  // Scoreboard: every applied pulse must match the next expected select
  always @(negedge clk) begin
    if (reset_n && applied) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_applied", 1, 0);
      end else begin
        check_eq("applied_select", int'(select), exp_q.pop_front());
      end
    end
  end

  initial begin
    reset_n = 1'b0; vblank_start = 1'b0; req_valid = 1'b0; req_sel = 2'd0;
    step_btn = 1'b0; auto_en = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc();

    // Reset state and quiet idle
    check_eq("rst_select", int'(select), 0);
    check_eq("rst_pending", int'(pending), 0);
    check_eq("rst_ready", int'(req_ready), 1);
    cyc(10);
    check_eq("idle_select", int'(select), 0);
    check_eq("idle_pending", int'(pending), 0);

    // Host request mid-frame, applied at next vblank
    host_req(2'd2);
    check_eq("req_pending", int'(pending), 1);
    check_eq("req_ready_low", int'(req_ready), 0);
    cyc(3);
    check_eq("req_hold_select", int'(select), 0);
    exp_q.push_back(2);
    pulse_vblank();
    check_eq("req_applied_sel", int'(select), 2);
    check_eq("req_applied_pend", int'(pending), 0);
    cyc();
    check_eq("applied_one_cycle", int'(applied), 0);

    // Move to select=1, then three presses accumulate 2,3,0
    host_req(2'd1);
    exp_q.push_back(1);
    pulse_vblank();
    check_eq("sel_one", int'(select), 1);
    press_step();
    check_eq("step1_staged", int'(dut.staged_reg), 2);
    press_step();
    check_eq("step2_staged", int'(dut.staged_reg), 3);
    press_step();
    check_eq("step3_staged", int'(dut.staged_reg), 0);
    check_eq("step_sel_hold", int'(select), 1);
    exp_q.push_back(0);
    pulse_vblank();
    check_eq("step_wrap_sel", int'(select), 0);

    // Request and press in the same cycle: request wins
    req_valid = 1'b1; req_sel = 2'd3; step_btn = 1'b1;
    cyc();
    req_valid = 1'b0; step_btn = 1'b0;
    cyc();
    check_eq("tie_staged", int'(dut.staged_reg), 3);
    // Second request held while pending stays unaccepted
    req_valid = 1'b1; req_sel = 2'd1;
    cyc(3);
    check_eq("blocked_ready", int'(req_ready), 0);
    check_eq("blocked_staged", int'(dut.staged_reg), 3);
    exp_q.push_back(3);
    pulse_vblank();
    check_eq("tie_sel", int'(select), 3);
    check_eq("tie_ready_back", int'(req_ready), 1);
    cyc();
    req_valid = 1'b0;
    check_eq("second_accepted", int'(pending), 1);
    check_eq("second_staged", int'(dut.staged_reg), 1);
    exp_q.push_back(1);
    pulse_vblank();
    check_eq("second_sel", int'(select), 1);
    host_req(2'd0);
    exp_q.push_back(0);
    pulse_vblank();
    check_eq("back_to_zero", int'(select), 0);

    // Auto cycling with a 4-frame period
    auto_en = 1'b1;
    exp_sel = 0;
    cyc(2);
    for (int k = 1; k <= 12; k++) begin
      if (k % 4 == 0) begin
        exp_sel = (exp_sel + 1) % 4;
        exp_q.push_back(exp_sel);
      end
      pulse_vblank();
      check_eq($sformatf("auto_pulse%0d", k), int'(select), exp_sel);
      cyc(3);
    end

    // Staged apply restarts the counter
    for (int k = 1; k <= 5; k++) begin
      if (k == 4) begin
        exp_sel = (exp_sel + 1) % 4;
        exp_q.push_back(exp_sel);
      end
      pulse_vblank();
      cyc(2);
    end
    check_eq("auto_pre_req", int'(select), 0);
    host_req(2'd2);
    exp_q.push_back(2);
    pulse_vblank();
    check_eq("auto_req_applied", int'(select), 2);
    cyc(2);
    for (int k = 1; k <= 3; k++) begin
      pulse_vblank();
      cyc(2);
    end
    check_eq("counter_restart_hold", int'(select), 2);
    exp_q.push_back(3);
    pulse_vblank();
    check_eq("counter_restart_tick", int'(select), 3);
    auto_en = 1'b0;
    cyc(2);

    // Reset while staged discards the staged value
    host_req(2'd3);
    check_eq("pre_rst_pending", int'(pending), 1);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    check_eq("mid_rst_select", int'(select), 0);
    check_eq("mid_rst_pending", int'(pending), 0);
    check_eq("mid_rst_ready", int'(req_ready), 1);
    pulse_vblank();
    check_eq("post_rst_vblank_sel", int'(select), 0);
    check_eq("post_rst_applied", int'(applied), 0);
    cyc(3);

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
